// File: rtl/cpu0_mem_arbiter_pkg.sv
// cpu0_mem_pkg: shared encodings for the CPU0 memory arbiter.
// State, size and owner codes plus the word beat count.
package cpu0_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_RESP
   } state_t;

   typedef enum logic {
      OWN_F,
      OWN_D
   } owner_t;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   localparam int BEATS_WORD = 4;

   // Big-endian: beat 0 carries the most significant byte.
   function automatic logic [7:0] beat_byte(
      input logic [31:0] w,
      input logic [1:0]  k
   );
      logic [7:0] b;
      unique case (k)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// cpu0_mem_arbiter_if: fetch port, data port and byte memory bus.
// slave = arbiter side, master = core and memory side.
interface cpu0_mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);

   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_done;
   logic [DW-1:0] f_rdata;
   logic          f_err;

   logic          d_req;
   logic          d_we;
   logic          d_size;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          d_err;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   modport slave (
      input  f_req, f_addr,
      output f_gnt, f_done, f_rdata, f_err,
      input  d_req, d_we, d_size, d_addr, d_wdata,
      output d_gnt, d_done, d_rdata, d_err,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output f_req, f_addr,
      input  f_gnt, f_done, f_rdata, f_err,
      output d_req, d_we, d_size, d_addr, d_wdata,
      input  d_gnt, d_done, d_rdata, d_err,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/cpu0_mem_arbiter_beat_seq.sv
// cpu0_mem_beat_seq: beat counter, address wrap, write byte select
// and big-endian read assembly for one granted access.
module cpu0_mem_beat_seq
   import cpu0_mem_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          load,
   input  logic          quiet,
   input  logic          issue,
   input  logic          drain,
   input  logic [AW-1:0] a_addr,
   input  logic          a_we,
   input  logic          a_size,
   input  logic [DW-1:0] a_wdata,
   input  logic [7:0]    mem_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [7:0]    mem_wdata,
   output logic          wr,
   output logic          last,
   output logic [DW-1:0] rdata
);

   logic [AW-1:0] base;
   logic          size;
   logic [DW-1:0] wdata;
   logic [1:0]    cnt;
   logic [1:0]    nxt;
   logic          cap;

   assign nxt  = cnt + 2'd1;
   assign last = (size == SZ_WORD)
               ? (cnt == 2'(BEATS_WORD - 1))
               : 1'b1;
   // Read data trails the address by one cycle.
   assign cap  = !wr && ((issue && cnt != 2'd0) || drain);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base      <= '0;
         size      <= SZ_BYTE;
         wdata     <= '0;
         wr        <= 1'b0;
         cnt       <= 2'd0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= 8'h00;
      end else begin
         if (load) begin
            base  <= a_addr;
            size  <= a_size;
            wdata <= a_wdata;
            wr    <= a_we;
            cnt   <= 2'd0;
            rdata <= '0;
            if (quiet) begin
               mem_we <= 1'b0;
            end else begin
               mem_addr  <= a_addr;
               mem_we    <= a_we;
               mem_wdata <= (a_size == SZ_WORD)
                          ? beat_byte(a_wdata, 2'd0)
                          : a_wdata[7:0];
            end
         end else if (issue) begin
            if (last) begin
               mem_we <= 1'b0;
            end else begin
               cnt       <= nxt;
               mem_addr  <= base + AW'(nxt);
               mem_wdata <= beat_byte(wdata, nxt);
            end
         end
         if (cap)
            rdata <= {rdata[DW-9:0], mem_rdata};
      end
   end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// cpu0_mem_arbiter: data-over-fetch arbiter for CPU0 byte memory.
// CPU0_MEM_ARB_ALIGN_CHECK_EN: fail unaligned word accesses with err.
module cpu0_mem_arbiter
   import cpu0_mem_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 32
) (
   input logic               clock,
   input logic               reset_n,
   cpu0_mem_arbiter_if.slave bus
);

   state_t        state;
   owner_t        owner;
   logic          f_gnt_q;
   logic          d_gnt_q;
   logic          f_done_q;
   logic          d_done_q;
   logic          err_q;
   logic          bad;

   logic          arb;
   logic          take;
   logic          pick_d;
   logic          misalign;
   logic [AW-1:0] a_addr;
   logic          a_we;
   logic          a_size;
   logic          last;
   logic          wr;
   logic [DW-1:0] rdata;

   assign arb    = (state == ST_IDLE) || (state == ST_RESP);
   assign take   = arb && (bus.d_req || bus.f_req);
   assign pick_d = bus.d_req;

   // Fetch is always a word read, whatever the data port shows.
   assign a_addr = pick_d ? bus.d_addr : bus.f_addr;
   assign a_we   = pick_d && bus.d_we;
   assign a_size = pick_d ? bus.d_size : SZ_WORD;

`ifdef CPU0_MEM_ARB_ALIGN_CHECK_EN
   assign misalign = (a_size == SZ_WORD) && (a_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   cpu0_mem_beat_seq #(
      .AW(AW),
      .DW(DW)
   ) u_seq (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (take),
      .quiet     (misalign),
      .issue     ((state == ST_ISSUE) && !bad),
      .drain     (state == ST_DRAIN),
      .a_addr    (a_addr),
      .a_we      (a_we),
      .a_size    (a_size),
      .a_wdata   (bus.d_wdata),
      .mem_rdata (bus.mem_rdata),
      .mem_addr  (bus.mem_addr),
      .mem_we    (bus.mem_we),
      .mem_wdata (bus.mem_wdata),
      .wr        (wr),
      .last      (last),
      .rdata     (rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         owner    <= OWN_F;
         bad      <= 1'b0;
         f_gnt_q  <= 1'b0;
         d_gnt_q  <= 1'b0;
         f_done_q <= 1'b0;
         d_done_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         f_gnt_q  <= 1'b0;
         d_gnt_q  <= 1'b0;
         f_done_q <= 1'b0;
         d_done_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state)
            ST_IDLE, ST_RESP: begin
               if (take) begin
                  state   <= ST_ISSUE;
                  owner   <= pick_d ? OWN_D : OWN_F;
                  bad     <= misalign;
                  d_gnt_q <= pick_d;
                  f_gnt_q <= !pick_d;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (bad || (last && wr)) begin
                  state    <= ST_RESP;
                  d_done_q <= (owner == OWN_D);
                  f_done_q <= (owner == OWN_F);
                  err_q    <= bad;
               end else if (last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state    <= ST_RESP;
               d_done_q <= (owner == OWN_D);
               f_done_q <= (owner == OWN_F);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.f_gnt   = f_gnt_q;
   assign bus.d_gnt   = d_gnt_q;
   assign bus.f_done  = f_done_q;
   assign bus.d_done  = d_done_q;
   assign bus.f_rdata = f_done_q ? rdata : '0;
   assign bus.d_rdata = d_done_q ? rdata : '0;
   assign bus.f_err   = f_done_q & err_q;
   assign bus.d_err   = d_done_q & err_q;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// tb_cpu0_mem_arbiter: directed bench with a byte memory model
// and a done-ordered scoreboard for both requesters.
module tb_cpu0_mem_arbiter;
   import cpu0_mem_pkg::*;

   localparam int AW = 16;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   cpu0_mem_arbiter_if #(.AW(AW), .DW(32)) bus ();

   cpu0_mem_arbiter #(.AW(AW), .DW(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
      string       tag;
   } exp_t;

   logic [7:0]  mem [0:65535];
   int unsigned cyc = 0;
   int          we_cnt = 0;
   exp_t        sb [$];
   int          checks = 0;
   int          failures = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(posedge clock) begin
      if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         we_cnt <= we_cnt + 1;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.f_gnt || bus.d_gnt || bus.f_done || bus.d_done)
            chk("exclusive", {bus.f_gnt & bus.d_gnt, bus.f_done & bus.d_done}, 0);
         if (bus.f_done || bus.d_done) begin
            chk("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk({e.tag, "_port"}, bus.d_done, e.port);
               chk({e.tag, "_cyc"}, cyc, e.cyc);
               chk({e.tag, "_rdata"},
                   e.port ? bus.d_rdata : bus.f_rdata, e.rdata);
               chk({e.tag, "_err"},
                   e.port ? bus.d_err : bus.f_err, e.err);
               chk({e.tag, "_other"},
                   e.port ? {bus.f_rdata, bus.f_err}
                          : {bus.d_rdata, bus.d_err}, 0);
            end
         end
      end
   end

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 30; i++) begin
         @(posedge clock);
         if (sb.size() == 0) break;
      end
      chk({tag, "_drain"}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic issue(input logic port, input logic we,
                        input logic size, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] er,
                        input logic ee, input int lat,
                        input string tag);
      int g;
      exp_t e;
      g = -1;
      @(posedge clock); #1;
      if (port) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
         bus.d_addr = addr; bus.d_wdata = wd;
      end else begin
         bus.f_req = 1'b1; bus.f_addr = addr;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (port ? bus.d_gnt : bus.f_gnt) begin
            g = int'(cyc);
            break;
         end
      end
      bus.d_req = 1'b0;
      bus.f_req = 1'b0;
      chk({tag, "_gnt"}, g >= 0, 1);
      if (g >= 0) begin
         e.port = port; e.rdata = er; e.err = ee;
         e.cyc = g + lat; e.tag = tag;
         sb.push_back(e);
      end
      wait_drain(tag);
   endtask

   function automatic logic [31:0] word_at(input logic [15:0] a);
      logic [15:0] a1, a2, a3;
      a1 = a + 16'd1; a2 = a + 16'd2; a3 = a + 16'd3;
      return {mem[a], mem[a1], mem[a2], mem[a3]};
   endfunction

   initial begin
      logic [7:0]  old22, old42, old43;
      logic [31:0] exp_f, exp_u;
      int gd, gf, w0;
      exp_t e;

      for (int i = 0; i < 65536; i++)
         mem[i] = 8'(i) ^ 8'h5A;
      bus.f_req = 0; bus.f_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
      bus.d_addr = '0; bus.d_wdata = '0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_flags", {bus.f_gnt, bus.f_done, bus.f_err, bus.d_gnt,
                        bus.d_done, bus.d_err, bus.mem_we}, 0);
      chk("rst_data", {bus.f_rdata, bus.d_rdata}, 0);
      chk("rst_addr", {bus.mem_addr, bus.mem_wdata}, 0);
      reset_n = 1'b1;

      issue(1, 1, SZ_WORD, 16'h0010, 32'h11223344, 0, 0, 4, "ww");
      chk("ww_mem", word_at(16'h0010), 32'h11223344);
      issue(1, 0, SZ_WORD, 16'h0010, 0, 32'h11223344, 0, 5, "wr");

      mem[16'h0020] = 8'hF5;
      old22 = mem[16'h0022];
      issue(1, 0, SZ_BYTE, 16'h0020, 0, 32'h000000F5, 0, 2, "br");
      issue(1, 1, SZ_BYTE, 16'h0021, 32'hDEADBEAB, 0, 0, 1, "bw");
      chk("bw_mem", {mem[16'h0020], mem[16'h0021], mem[16'h0022]},
          {8'hF5, 8'hAB, old22});

      exp_f = word_at(16'h0100);
      bus.d_we = 1; bus.d_size = SZ_BYTE;
      issue(0, 0, SZ_WORD, 16'h0100, 0, exp_f, 0, 5, "fr");

      exp_f = word_at(16'h0200);
      gd = -1; gf = -1;
      @(posedge clock); #1;
      bus.d_req = 1; bus.d_we = 1; bus.d_size = SZ_WORD;
      bus.d_addr = 16'h0030; bus.d_wdata = 32'hCAFEF00D;
      bus.f_req = 1; bus.f_addr = 16'h0200;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus.d_gnt && gd < 0) begin
            gd = int'(cyc); bus.d_req = 0;
            e.port = 1; e.rdata = 0; e.err = 0;
            e.cyc = gd + 4; e.tag = "sim_d";
            sb.push_back(e);
         end
         if (bus.f_gnt && gf < 0) begin
            gf = int'(cyc); bus.f_req = 0;
            e.port = 0; e.rdata = exp_f; e.err = 0;
            e.cyc = gf + 5; e.tag = "sim_f";
            sb.push_back(e);
         end
         if (gd >= 0 && gf >= 0) break;
      end
      bus.d_req = 0; bus.f_req = 0;
      chk("sim_d_first", (gd >= 0) && (gf > gd), 1);
      chk("sim_f_gnt", gf, gd + 5);
      wait_drain("sim");
      chk("sim_mem", word_at(16'h0030), 32'hCAFEF00D);

      issue(1, 1, SZ_WORD, 16'hFFFE, 32'hA1B2C3D4, 0, 0, 4, "wrap_w");
      chk("wrap_mem", {mem[16'hFFFE], mem[16'hFFFF],
                       mem[16'h0000], mem[16'h0001]}, 32'hA1B2C3D4);
      issue(1, 0, SZ_WORD, 16'hFFFE, 0, 32'hA1B2C3D4, 0, 5, "wrap_r");

      w0 = we_cnt;
      exp_u = word_at(16'h0002);
`ifdef CPU0_MEM_ARB_ALIGN_CHECK_EN
      issue(1, 0, SZ_WORD, 16'h0002, 0, 0, 1, 1, "unal");
`else
      issue(1, 0, SZ_WORD, 16'h0002, 0, exp_u, 0, 5, "unal");
`endif
      chk("unal_no_we", we_cnt - w0, 0);

      old42 = mem[16'h0042];
      old43 = mem[16'h0043];
      gd = -1;
      @(posedge clock); #1;
      bus.d_req = 1; bus.d_we = 1; bus.d_size = SZ_WORD;
      bus.d_addr = 16'h0040; bus.d_wdata = 32'h55667788;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.d_gnt) begin
            gd = int'(cyc);
            break;
         end
      end
      bus.d_req = 0;
      chk("rmid_gnt", gd >= 0, 1);
      repeat (2) @(posedge clock);
      #1;
      chk("rmid_beat2", {bus.mem_we, bus.mem_addr}, {1'b1, 16'h0042});
      reset_n = 1'b0;
      #1;
      chk("rmid_out", {bus.mem_we, bus.mem_addr, bus.d_gnt,
                       bus.d_done, bus.f_gnt, bus.f_done}, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (8) @(posedge clock);
      chk("rmid_mem", word_at(16'h0040),
          {8'h55, 8'h66, old42, old43});
      issue(0, 0, SZ_WORD, 16'h0040, 0,
            {8'h55, 8'h66, old42, old43}, 0, 5, "rmid_f");

      repeat (3) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
